// File: rtl/led_pkg.sv
// Shared encodings and default sizing for the LED sequencer.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int unsigned DEF_N_LEDS     = 8;
  localparam int unsigned DEF_PRESCALE_W = 16;
  localparam int unsigned DEF_PWM_W      = 4;

endpackage

// File: rtl/led_prescaler.sv
// Step-period counter: counts 0..period while enabled and flags the wrap cycle.
module led_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] period_i,
  output logic                  tick_o,
  output logic [PRESCALE_W-1:0] count_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick_o  = enable_i && (cnt_q == period_i);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == period_i) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED bank controller: handshake-loaded mode/period/duty, stepped pattern
// (off/on/blink/chase) gated by a PWM brightness enable.
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS     = DEF_N_LEDS,
  parameter int unsigned PRESCALE_W = DEF_PRESCALE_W,
  parameter int unsigned PWM_W      = DEF_PWM_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [1:0]            i_cfg_mode,
  input  logic [PRESCALE_W-1:0] i_cfg_period,
  input  logic [PWM_W-1:0]      i_cfg_duty,
  output logic [N_LEDS-1:0]     o_led,
  output logic                  o_tick,
  output logic                  o_busy
);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [PRESCALE_W-1:0] period_q, period_d;
  logic [PWM_W-1:0]      duty_q, duty_d;
  logic [N_LEDS-1:0]     pattern_q, pattern_d;
  logic [PWM_W-1:0]      pwm_q, pwm_d;

  logic                  accept;
  logic                  pre_clear;
  logic                  pre_enable;
  logic                  pre_tick;
  logic [PRESCALE_W-1:0] pre_count;
  logic                  pwm_en;

  assign o_cfg_ready = (state_q != ST_LOAD);
  assign o_busy      = (state_q != ST_IDLE);
  assign accept      = i_cfg_valid & o_cfg_ready;
  assign pre_enable  = (state_q == ST_RUN);
  assign o_tick      = pre_tick;

  assign pwm_en = (&duty_q) | (pwm_q < duty_q);
  assign o_led  = pattern_q & {N_LEDS{pwm_en}};

  led_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk_i    (i_clock),
    .rst_ni   (i_reset_n),
    .clear_i  (pre_clear),
    .enable_i (pre_enable),
    .period_i (period_q),
    .tick_o   (pre_tick),
    .count_o  (pre_count)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    period_d  = period_q;
    duty_d    = duty_q;
    pattern_d = pattern_q;
    pwm_d     = pwm_q;
    pre_clear = 1'b0;

    if (accept) begin
      mode_d   = mode_e'(i_cfg_mode);
      period_d = i_cfg_period;
      duty_d   = i_cfg_duty;
    end

    case (state_q)
      ST_IDLE: begin
        pattern_d = '0;
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pre_clear = 1'b1;
        pwm_d     = '0;
        case (mode_q)
          MODE_ON, MODE_BLINK: pattern_d = '1;
          MODE_CHASE:          pattern_d = {{(N_LEDS-1){1'b0}}, 1'b1};
          default:             pattern_d = '0;
        endcase
        state_d = (mode_q == MODE_OFF) ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        pwm_d = pwm_q + 1'b1;
        // A fresh configuration beat wins over a coincident step tick.
        if (accept) begin
          state_d = ST_LOAD;
        end else if (pre_tick) begin
          case (mode_q)
            MODE_BLINK: pattern_d = ~pattern_q;
            MODE_CHASE: pattern_d = {pattern_q[N_LEDS-2:0], pattern_q[N_LEDS-1]};
            default:    pattern_d = pattern_q;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      period_q  <= '0;
      duty_q    <= '1;
      pattern_q <= '0;
      pwm_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      period_q  <= period_d;
      duty_q    <= duty_d;
      pattern_q <= pattern_d;
      pwm_q     <= pwm_d;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with hand-computed expectations.
module tb_led_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [1:0]  cfg_mode = 2'd0;
  logic [15:0] cfg_period = '0;
  logic [3:0]  cfg_duty = '0;
  logic [7:0]  led;
  logic        tick;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS     (8),
    .PRESCALE_W (16),
    .PWM_W      (4)
  ) dut (
    .i_clock      (clk),
    .i_reset_n    (rst_n),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_mode   (cfg_mode),
    .i_cfg_period (cfg_period),
    .i_cfg_duty   (cfg_duty),
    .o_led        (led),
    .o_tick       (tick),
    .o_busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [15:0] p, input logic [3:0] d);
    cfg_valid  = 1'b1;
    cfg_mode   = m;
    cfg_period = p;
    cfg_duty   = d;
  endtask

  initial begin
    logic [7:0] exp_led;

    // Reset state before any clock edge
    #1;
    check("rst_led", 32'(led), 32'h00);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // CHASE period=3 duty=15
    cfg(2'd3, 16'd3, 4'd15);
    cyc(1);
    check("chase_load_ready", 32'(cfg_ready), 32'd0);
    check("chase_load_busy", 32'(busy), 32'd1);
    cfg_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 36; i++) begin
      exp_led = 8'h01 << ((i / 4) % 8);
      check("chase_led", 32'(led), 32'(exp_led));
      check("chase_tick", 32'(tick), 32'((i % 4) == 3));
      cyc(1);
    end

    // Asynchronous reset mid-CHASE, no clock edge involved
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'h00);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tick", 32'(tick), 32'd0);
    rst_n = 1'b1;
    cyc(3);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_led", 32'(led), 32'h00);

    // BLINK period=0 duty=15
    cfg(2'd2, 16'd0, 4'd15);
    cyc(1);
    cfg_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      check("blink_led", 32'(led), (i % 2 == 0) ? 32'hFF : 32'h00);
      check("blink_tick", 32'(tick), 32'd1);
      cyc(1);
    end

    // ON duty=4, then duty=0
    cfg(2'd1, 16'd0, 4'd4);
    cyc(1);
    check("on_load_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 32; i++) begin
      check("on4_led", 32'(led), ((i % 16) < 4) ? 32'hFF : 32'h00);
      cyc(1);
    end
    cfg(2'd1, 16'd0, 4'd0);
    cyc(1);
    cfg_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 16; i++) begin
      check("on0_led", 32'(led), 32'h00);
      cyc(1);
    end

    // Reconfigure on a tick cycle, with a held valid giving a second beat
    cfg(2'd3, 16'd3, 4'd15);
    cyc(1);
    cfg_valid = 1'b0;
    cyc(12);
    check("rc_pre_led", 32'(led), 32'h04);
    check("rc_pre_tick", 32'(tick), 32'd1);
    cfg(2'd3, 16'd1, 4'd15);
    cyc(1);
    check("rc_load_ready", 32'(cfg_ready), 32'd0);
    check("rc_load_tick", 32'(tick), 32'd0);
    check("rc_tick_discarded", 32'(led), 32'h04);
    cfg(2'd2, 16'd1, 4'd15);
    cyc(1);
    check("rc_run_led", 32'(led), 32'h01);
    check("rc_run_ready", 32'(cfg_ready), 32'd1);
    check("rc_run_tick", 32'(tick), 32'd0);
    cyc(1);
    cfg_valid = 1'b0;
    check("rc_beat2_ready", 32'(cfg_ready), 32'd0);
    cyc(1);
    check("rc_beat2_led0", 32'(led), 32'hFF);
    check("rc_beat2_tick0", 32'(tick), 32'd0);
    cyc(1);
    check("rc_beat2_led1", 32'(led), 32'hFF);
    check("rc_beat2_tick1", 32'(tick), 32'd1);
    cyc(1);
    check("rc_beat2_led2", 32'(led), 32'h00);

    // OFF from RUN
    cfg(2'd0, 16'd0, 4'd15);
    cyc(1);
    check("off_load_busy", 32'(busy), 32'd1);
    check("off_load_ready", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      check("off_busy", 32'(busy), 32'd0);
      check("off_led", 32'(led), 32'h00);
      check("off_tick", 32'(tick), 32'd0);
      check("off_ready", 32'(cfg_ready), 32'd1);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
